// File: rtl/axi4_mult_pkg.sv
// Shared types and constants for the AXI4-style multiplier slave.
// Holds the write/read FSM state encodings, response codes, the address
// map and helpers that derive beat counts from operand and beat widths.
package axi4_mult_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  localparam logic RESP_OK  = 1'b1;
  localparam logic RESP_ERR = 1'b0;

  localparam int ADDR_A   = 0;
  localparam int ADDR_B   = 1;
  localparam int ADDR_RES = 0;

  // Beats needed to carry one operand.
  function automatic int op_beats(input int sz, input int dsz);
    return sz / dsz;
  endfunction

  // Beats needed to carry the double-width product.
  function automatic int res_beats(input int sz, input int dsz);
    return (2 * sz) / dsz;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, _rst : clock and synchronous active-low reset
//   start     : load a/b and begin (ignored while busy)
//   a, b      : SZ-bit unsigned operands
//   busy      : computation in flight
//   done      : one-cycle pulse, high in the cycle before p takes the result
//   p         : 2*SZ-bit product register
// Timing: start seen at edge S, SZ iteration edges, p written at S+SZ+1.
module seq_mult #(
  parameter int SZ = 32
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic            start,
  input  logic [SZ-1:0]   a,
  input  logic [SZ-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*SZ-1:0] p
);

  localparam int CW = $clog2(SZ + 1);

  logic [2*SZ-1:0] mcand;
  logic [2*SZ-1:0] acc;
  logic [SZ-1:0]   mplier;
  logic [CW-1:0]   count;

  // Final write-back cycle: iterations exhausted, result about to land in p.
  assign done = busy && (count == '0);

  always_ff @(posedge clk) begin
    if (!_rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
      p      <= '0;
    end else if (!busy) begin
      if (start) begin
        mcand  <= {{SZ{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        count  <= CW'(SZ);
        busy   <= 1'b1;
      end
    end else if (count != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end else begin
      p    <= acc;
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4_mult_slave.sv
// AXI4-style slave wrapping a sequential multiplier.
// Write address 0/1 loads operand A/B as an SZ/DSZ-beat burst; once both
// operands are fresh the multiplier runs and the 2*SZ-bit product can be
// read from read address 0 as a 2*SZ/DSZ-beat burst, low beat first.
// Ports:
//   clk, _rst          : clock, synchronous active-low reset
//   aw*/w*/b*          : write address, write data, write response
//   ar*/r*             : read address, read data (bresp/rresp 1 = ok)
// Handshake: every channel transfers on a rising edge where valid and ready
// are both high; the source holds valid and payload steady until then.
// All outputs are driven straight from flops.
module axi4_mult_slave
  import axi4_mult_pkg::*;
#(
  parameter int SZ  = 32,
  parameter int ASZ = 2,
  parameter int DSZ = 8
) (
  input  logic           clk,
  input  logic           _rst,
  input  logic [ASZ-1:0] awaddr,
  input  logic           awvalid,
  output logic           awready,
  input  logic [DSZ-1:0] wdata,
  input  logic           wvalid,
  output logic           wready,
  input  logic           wlast,
  output logic           bresp,
  output logic           bvalid,
  input  logic           bready,
  input  logic [ASZ-1:0] araddr,
  input  logic           arvalid,
  output logic           arready,
  output logic [DSZ-1:0] rdata,
  output logic           rvalid,
  input  logic           rready,
  output logic           rlast,
  output logic           rresp
);

  localparam int OPB = op_beats(SZ, DSZ);
  localparam int RSB = res_beats(SZ, DSZ);
  localparam int WCW = $clog2(OPB + 1);
  localparam int RCW = $clog2(RSB + 1);

  wstate_t         w_state;
  logic [ASZ-1:0]  w_addr;
  logic [WCW-1:0]  w_cnt;
  logic [SZ-1:0]   shadow;
  logic [SZ-1:0]   merged;
  logic [SZ-1:0]   op_a;
  logic [SZ-1:0]   op_b;
  logic            a_new;
  logic            b_new;
  logic            res_valid;
  logic            w_fire;
  logic            w_ok;
  logic            commit_a;
  logic            commit_b;
  logic            start;
  logic            mult_busy;
  logic            mult_done;
  logic [2*SZ-1:0] product;

  rstate_t         r_state;
  logic [2*SZ-1:0] r_buf;
  logic [RCW-1:0]  r_beat;
  logic            rd_ok;

  // Shadow with the current beat folded in, so the last beat can commit
  // the whole operand on the same edge. w_cnt saturates at OPB, which
  // drops any surplus beats.
  always_comb begin
    merged = shadow;
    if (w_cnt < WCW'(OPB)) merged[int'(w_cnt) * DSZ +: DSZ] = wdata;
  end

  assign w_fire   = (w_state == W_DATA) && wvalid && wready;
  assign w_ok     = (w_addr <= ASZ'(ADDR_B)) && (w_cnt == WCW'(OPB - 1));
  assign commit_a = w_fire && wlast && w_ok && (w_addr == ASZ'(ADDR_A));
  assign commit_b = w_fire && wlast && w_ok && (w_addr == ASZ'(ADDR_B));
  assign start    = a_new && b_new && !mult_busy;
  assign rd_ok    = (araddr == ASZ'(ADDR_RES));

  always_ff @(posedge clk) begin
    if (!_rst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 1'b0;
      w_addr  <= '0;
      w_cnt   <= '0;
      shadow  <= '0;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            w_addr  <= awaddr;
            w_cnt   <= '0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready) begin
            shadow <= merged;
            if (w_cnt != WCW'(OPB)) w_cnt <= w_cnt + WCW'(1);
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= w_ok ? RESP_OK : RESP_ERR;
              if (commit_a) op_a <= merged;
              if (commit_b) op_b <= merged;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            bresp   <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Fresh-operand flags. A commit landing on the start edge re-arms its
  // flag, so the start clear must come first.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      a_new     <= 1'b0;
      b_new     <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (start) begin
        a_new <= 1'b0;
        b_new <= 1'b0;
      end
      if (commit_a) a_new <= 1'b1;
      if (commit_b) b_new <= 1'b1;
      if (mult_done) res_valid <= 1'b1;
    end
  end

  seq_mult #(.SZ(SZ)) u_mult (
    .clk   (clk),
    ._rst  (_rst),
    .start (start),
    .a     (op_a),
    .b     (op_b),
    .busy  (mult_busy),
    .done  (mult_done),
    .p     (product)
  );

  // Read side: the product is copied into r_buf at AR time and shifted out,
  // so a later product update cannot reach a burst already in progress.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= 1'b0;
      rdata   <= '0;
      r_buf   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          // res_valid | mult_done lets arready rise with res_valid.
          arready <= res_valid || mult_done;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rresp   <= rd_ok ? RESP_OK : RESP_ERR;
            rdata   <= rd_ok ? product[DSZ-1:0] : '0;
            r_buf   <= rd_ok ? (product >> DSZ) : '0;
            r_beat  <= '0;
            rlast   <= (RSB == 1);
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rresp   <= 1'b0;
              rdata   <= '0;
              arready <= res_valid || mult_done;
              r_state <= R_IDLE;
            end else begin
              rdata  <= r_buf[DSZ-1:0];
              r_buf  <= r_buf >> DSZ;
              r_beat <= r_beat + RCW'(1);
              rlast  <= (r_beat == RCW'(RSB - 2));
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mult_slave.sv
// Self-checking bench for axi4_mult_slave: directed scenarios plus random
// operand pairs, compared against a timeline model of committed operands
// and the products they produce.
module tb_axi4_mult_slave;

  localparam int SZ  = 32;
  localparam int ASZ = 2;
  localparam int DSZ = 8;
  localparam int OPB = SZ / DSZ;
  localparam int RSB = 2 * SZ / DSZ;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic _rst = 1'b0;
  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ASZ-1:0] awaddr = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DSZ-1:0] wdata = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic           wlast = 1'b0;
  logic           bresp;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [ASZ-1:0] araddr = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [DSZ-1:0] rdata;
  logic           rvalid;
  logic           rready = 1'b0;
  logic           rlast;
  logic           rresp;

  axi4_mult_slave #(.SZ(SZ), .ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk(clk), ._rst(_rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DSZ-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: committed operands, fresh flags, and a timeline of products
  // (edge at which each product becomes visible, and its value).
  logic [SZ-1:0]   m_a, m_b;
  bit              m_a_new, m_b_new;
  longint unsigned m_free;
  longint unsigned pc_q[$];
  logic [63:0]     pv_q[$];
  longint unsigned last_w_cyc;

  task automatic model_reset();
    m_a = '0; m_b = '0; m_a_new = 0; m_b_new = 0; m_free = 0;
    pc_q.delete(); pv_q.delete();
  endtask

  // Pair completing at edge c: multiplier starts at the next edge it is
  // free and the product lands SZ+1 edges after that start.
  task automatic model_commit(input int addr, input logic [SZ-1:0] data, input longint unsigned c);
    longint unsigned s;
    if (addr == 0) begin m_a = data; m_a_new = 1; end
    else begin m_b = data; m_b_new = 1; end
    if (m_a_new && m_b_new) begin
      s = (c + 1 > m_free) ? c + 1 : m_free;
      pc_q.push_back(s + SZ + 1);
      pv_q.push_back(64'(m_a) * 64'(m_b));
      m_free = s + SZ + 2;
      m_a_new = 0; m_b_new = 0;
    end
  endtask

  // Product captured by a read handshake at edge h.
  function automatic logic [63:0] model_product(input longint unsigned h);
    logic [63:0] v = '0;
    foreach (pc_q[i]) if (pc_q[i] < h) v = pv_q[i];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    _rst = 1'b0;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    model_reset();
    @(negedge clk);
    check("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata}, '0);
    @(negedge clk);
    _rst = 1'b1;
    @(negedge clk);
    check("awready_after_reset", awready, 1);
  endtask

  task automatic write_txn(input int addr, input logic [SZ-1:0] data, input int nbeats, input int abort_after);
    int budget;
    logic exp_ok;
    exp_ok = (addr <= 1) && (nbeats == OPB);
    @(negedge clk);
    awaddr = addr[ASZ-1:0];
    awvalid = 1'b1;
    budget = 0;
    while (!awready && budget < 50) begin @(negedge clk); budget++; end
    check("awready_seen", awready, 1);
    if (!awready) begin awvalid = 0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_after) return;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      wdata  = (i < OPB) ? data[i*DSZ +: DSZ] : DSZ'($urandom);
      wlast  = (i == nbeats - 1);
      wvalid = 1'b1;
      budget = 0;
      while (!wready && budget < 50) begin @(negedge clk); budget++; end
      if (!wready) begin
        check("wready_seen", wready, 1);
        wvalid = 0; wlast = 0;
        return;
      end
      @(negedge clk);
      wvalid = 1'b0;
      wlast  = 1'b0;
      last_w_cyc = cyc;
    end
    budget = 0;
    while (budget < 50) begin
      bready = ($urandom_range(0, 2) != 0);
      if (bvalid && bready) break;
      @(negedge clk);
      budget++;
    end
    check("bvalid_seen", bvalid, 1);
    check("bresp", bresp, exp_ok);
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", bvalid, 0);
    if (exp_ok) model_commit(addr, data, last_w_cyc);
  endtask

  // stall: 0 = rready always high, 1 = random, 2 = mostly low
  task automatic read_txn(input int addr, input int stall, input int abort_after);
    int budget, beat;
    longint unsigned h;
    logic [63:0] val;
    logic [DSZ-1:0] e;
    bit stalled;
    logic [DSZ:0] held;
    @(negedge clk);
    araddr = addr[ASZ-1:0];
    arvalid = 1'b1;
    budget = 0;
    while (!arready && budget < 200) begin @(negedge clk); budget++; end
    check("arready_seen", arready, 1);
    if (!arready) begin arvalid = 0; return; end
    h = cyc + 1;
    @(negedge clk);
    arvalid = 1'b0;
    val = (addr == 0) ? model_product(h) : 64'd0;
    exp_q.delete();
    for (int i = 0; i < RSB; i++) exp_q.push_back(val[i*DSZ +: DSZ]);
    beat = 0; stalled = 0; held = '0; budget = 0;
    while (exp_q.size() > 0 && budget < 400) begin
      if (beat == abort_after) begin rready = 0; return; end
      case (stall)
        0:       rready = 1'b1;
        1:       rready = ($urandom_range(0, 1) == 1);
        default: rready = ($urandom_range(0, 5) == 0);
      endcase
      if (rvalid) begin
        if (stalled) check("r_stable", {rlast, rdata}, held);
        if (rready) begin
          e = exp_q.pop_front();
          check("rdata", rdata, e);
          check("rlast", rlast, exp_q.size() == 0);
          check("rresp", rresp, addr == 0);
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = {rlast, rdata};
        end
      end
      @(negedge clk);
      budget++;
    end
    rready = 1'b0;
    check("r_beats_left", exp_q.size(), 0);
    check("rvalid_drop", rvalid, 0);
  endtask

  // First product after reset: arready must rise exactly SZ+2 edges after
  // the W handshake that completed the pair.
  task automatic wait_first_result(input longint unsigned c);
    int budget = 0;
    while (!arready && budget < 200) begin @(negedge clk); budget++; end
    check("result_latency", cyc - c, SZ + 2);
  endtask

  task automatic wait_product();
    int budget = 0;
    if (pc_q.size() == 0) return;
    while (cyc <= pc_q[$] + 1 && budget < 300) begin @(negedge clk); budget++; end
  endtask

  task automatic check_ar_blocked();
    int seen = 0;
    @(negedge clk);
    araddr = '0;
    arvalid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (arready) seen++;
    end
    arvalid = 1'b0;
    check("ar_blocked", seen, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [SZ-1:0] ra, rb;
  int first;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    do_reset();

    // 3 * 5, with exact result latency
    write_txn(0, 32'd3, OPB, -1);
    write_txn(1, 32'd5, OPB, -1);
    wait_first_result(last_w_cyc);
    read_txn(0, 0, -1);

    // max * max
    write_txn(0, 32'hFFFF_FFFF, OPB, -1);
    write_txn(1, 32'hFFFF_FFFF, OPB, -1);
    wait_product();
    read_txn(0, 1, -1);

    // read burst in flight while a new product lands
    write_txn(0, 32'd7, OPB, -1);
    write_txn(1, 32'd9, OPB, -1);
    read_txn(0, 2, -1);
    wait_product();
    read_txn(0, 0, -1);

    // error responses; operand A must survive bad writes
    write_txn(2, 32'h1234_5678, OPB, -1);
    write_txn(3, 32'h1111_2222, OPB, -1);
    read_txn(0, 1, -1);
    write_txn(0, 32'd11, OPB, -1);
    write_txn(0, 32'hDEAD_BEEF, 3, -1);
    write_txn(0, 32'hCAFE_F00D, OPB + 2, -1);
    write_txn(1, 32'd13, OPB, -1);
    wait_product();
    read_txn(0, 1, -1);

    // unmapped read addresses
    read_txn(1, 1, -1);
    read_txn(2, 0, -1);
    read_txn(3, 2, -1);

    // new A written mid-multiply must not disturb the running product
    write_txn(0, 32'h0001_0000, OPB, -1);
    write_txn(1, 32'h0001_0000, OPB, -1);
    write_txn(0, 32'd5, OPB, -1);
    wait_product();
    read_txn(0, 1, -1);
    write_txn(1, 32'd2, OPB, -1);
    wait_product();
    read_txn(0, 0, -1);

    // reset mid write burst
    write_txn(0, 32'hAAAA_5555, OPB, 2);
    do_reset();
    check_ar_blocked();
    write_txn(0, 32'd100, OPB, -1);
    write_txn(1, 32'd200, OPB, -1);
    wait_first_result(last_w_cyc);
    read_txn(0, 1, -1);

    // reset mid read burst
    read_txn(0, 1, 3);
    do_reset();
    check_ar_blocked();

    // random pairs
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 5))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = '1;
        1:       rb = SZ'($urandom_range(0, 255));
        default: rb = $urandom;
      endcase
      first = $urandom_range(0, 1);
      write_txn(first, first ? rb : ra, OPB, -1);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1)
          write_txn($urandom_range(2, 3), $urandom, OPB, -1);
        else
          write_txn($urandom_range(0, 1), $urandom, $urandom_range(0, 1) ? OPB - 1 : OPB + 1, -1);
      end
      write_txn(1 - first, first ? ra : rb, OPB, -1);
      wait_product();
      read_txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 2), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
